iomem_bus_ctrl: RTL and testbench



---
 rtl/iomem_bus_ctrl_if.sv | 33 +++
 rtl/iomem_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_iomem_bus_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_bus_ctrl_if.sv
// Bundles the PicoSoC iomem port and the peripheral slot bus into one interface.
// The controller connects through the slave modport; the environment uses master.
interface iomem_bus_ctrl_if #(
    parameter int NUM_SLOTS = 4
);
    logic                    iomem_valid;
    logic                    iomem_ready;
    logic [3:0]              iomem_wstrb;
    logic [31:0]             iomem_addr;
    logic [31:0]             iomem_wdata;
    logic [31:0]             iomem_rdata;

    logic [NUM_SLOTS-1:0]    slot_valid;
    logic [NUM_SLOTS-1:0]    slot_ready;
    logic [3:0]              slot_wstrb;
    logic [23:0]             slot_addr;
    logic [31:0]             slot_wdata;
    logic [32*NUM_SLOTS-1:0] slot_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output slot_ready, slot_rdata,
        input  iomem_ready, iomem_rdata,
        input  slot_valid, slot_wstrb, slot_addr, slot_wdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  slot_ready, slot_rdata,
        output iomem_ready, iomem_rdata,
        output slot_valid, slot_wstrb, slot_addr, slot_wdata
    );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// Routes PicoSoC iomem requests to one of NUM_SLOTS peripheral slots selected by addr[31:24],
// answering unmapped or unresponsive accesses with ERR_DATA instead of stalling the CPU.
module iomem_bus_ctrl #(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [7:0]  BASE_SLOT      = 8'h03,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             resetn,
    iomem_bus_ctrl_if.slave  bus,
    output logic             bus_err,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0]  NUM_SLOTS_B  = 8'(NUM_SLOTS);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [15:0]            timer_q, timer_d;
    logic                   iomem_ready_q, iomem_ready_d;
    logic [31:0]            iomem_rdata_q, iomem_rdata_d;
    logic [NUM_SLOTS-1:0]   slot_valid_q, slot_valid_d;
    logic [3:0]             slot_wstrb_q, slot_wstrb_d;
    logic [23:0]            slot_addr_q, slot_addr_d;
    logic [31:0]            slot_wdata_q, slot_wdata_d;
    logic                   bus_err_q, bus_err_d;
    logic [7:0]             err_count_q, err_count_d;

    logic [7:0]             idx;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;

    // The one-hot slot_valid register doubles as the slot select, so non-selected
    // ready bits and read data are masked out here.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_valid_q[i]) begin
                sel_ready = sel_ready | bus.slot_ready[i];
                sel_rdata = sel_rdata | bus.slot_rdata[32*i +: 32];
            end
        end
    end

    assign idx = bus.iomem_addr[31:24] - BASE_SLOT;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        iomem_ready_d = 1'b0;
        iomem_rdata_d = iomem_rdata_q;
        slot_valid_d  = slot_valid_q;
        slot_wstrb_d  = slot_wstrb_q;
        slot_addr_d   = slot_addr_q;
        slot_wdata_d  = slot_wdata_q;
        bus_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.iomem_valid) begin
                    slot_wstrb_d = bus.iomem_wstrb;
                    slot_addr_d  = bus.iomem_addr[23:0];
                    slot_wdata_d = bus.iomem_wdata;
                    if (idx < NUM_SLOTS_B) begin
                        state_d = ACCESS;
                        timer_d = 16'h0;
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            slot_valid_d[i] = (idx == 8'(i));
                        end
                    end else begin
                        state_d       = RESP;
                        iomem_ready_d = 1'b1;
                        iomem_rdata_d = ERR_DATA;
                        bus_err_d     = 1'b1;
                    end
                end
            end

            // A ready on the final timeout cycle is checked first so it completes normally.
            ACCESS: begin
                if (sel_ready) begin
                    state_d       = RESP;
                    iomem_ready_d = 1'b1;
                    iomem_rdata_d = sel_rdata;
                    slot_valid_d  = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d       = RESP;
                    iomem_ready_d = 1'b1;
                    iomem_rdata_d = ERR_DATA;
                    slot_valid_d  = '0;
                    bus_err_d     = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d      = IDLE;
                slot_valid_d = '0;
            end
        endcase

        err_count_d = err_count_q;
        if (bus_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            timer_q       <= 16'h0;
            iomem_ready_q <= 1'b0;
            iomem_rdata_q <= 32'h0;
            slot_valid_q  <= '0;
            slot_wstrb_q  <= 4'h0;
            slot_addr_q   <= 24'h0;
            slot_wdata_q  <= 32'h0;
            bus_err_q     <= 1'b0;
            err_count_q   <= 8'h0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            iomem_ready_q <= iomem_ready_d;
            iomem_rdata_q <= iomem_rdata_d;
            slot_valid_q  <= slot_valid_d;
            slot_wstrb_q  <= slot_wstrb_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            bus_err_q     <= bus_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.iomem_ready = iomem_ready_q;
    assign bus.iomem_rdata = iomem_rdata_q;
    assign bus.slot_valid  = slot_valid_q;
    assign bus.slot_wstrb  = slot_wstrb_q;
    assign bus.slot_addr   = slot_addr_q;
    assign bus.slot_wdata  = slot_wdata_q;
    assign bus_err         = bus_err_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Randomized self-checking bench for iomem_bus_ctrl: every transaction's expected timing,
// slot selection, read data and error accounting come from a transaction-level model.
module tb_iomem_bus_ctrl;

    localparam int          NSLOTS   = 4;
    localparam logic [7:0]  BASE     = 8'h03;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
    localparam int          NEVER    = 1000;

    logic       clk;
    logic       resetn;
    logic       bus_err;
    logic [7:0] err_count;

    int tests_run;
    int tests_failed;
    int exp_cnt;
    logic [31:0] exp_hold;

    iomem_bus_ctrl_if #(.NUM_SLOTS(NSLOTS)) bus ();

    iomem_bus_ctrl #(
        .NUM_SLOTS      (NSLOTS),
        .BASE_SLOT      (BASE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_DATA       (ERR_DATA)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .bus_err   (bus_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mapped slot with ready delay d (cycles after slot_valid appears) answers at
    // request cycle + d + 2 if d < TIMEOUT, else aborts at + TIMEOUT + 1; unmapped at + 1.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int delay, input bit late,
                          input bit noise, input bit fix, input logic [31:0] fix_val);
        logic [7:0]   idx8;
        bit           mapped;
        bit           err;
        int           resp_k;
        int           sel;
        logic [3:0]   oh;
        logic [3:0]   exp_sv;
        logic [3:0]   rdy;
        logic [127:0] rd;
        logic [31:0]  exp_rdata;

        idx8   = addr[31:24] - BASE;
        mapped = (int'(idx8) < NSLOTS);
        sel    = int'(idx8[1:0]);
        oh     = mapped ? (4'b0001 << idx8[1:0]) : 4'b0000;
        exp_rdata = ERR_DATA;
        if (!mapped) begin
            resp_k = 1;
            err    = 1'b1;
        end else if (delay <= TIMEOUT - 1) begin
            resp_k = delay + 2;
            err    = 1'b0;
        end else begin
            resp_k = TIMEOUT + 1;
            err    = 1'b1;
        end
        if (err && exp_cnt < 255) exp_cnt++;

        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = wstrb;
        bus.iomem_wdata = wdata;

        for (int k = 1; k <= resp_k + 1; k++) begin
            @(negedge clk);
            exp_sv = (mapped && k < resp_k) ? oh : 4'b0000;

            tests_run++;
            if (bus.iomem_ready !== (k == resp_k)) begin
                tests_failed++;
                $display("[TB] FAIL iomem_ready addr=%h k=%0d got %b want %b",
                         addr, k, bus.iomem_ready, (k == resp_k));
            end
            tests_run++;
            if (bus.slot_valid !== exp_sv) begin
                tests_failed++;
                $display("[TB] FAIL slot_valid addr=%h k=%0d got %b want %b",
                         addr, k, bus.slot_valid, exp_sv);
            end
            if (exp_sv != 4'b0000) begin
                tests_run++;
                if (bus.slot_addr !== addr[23:0] || bus.slot_wstrb !== wstrb ||
                    bus.slot_wdata !== wdata) begin
                    tests_failed++;
                    $display("[TB] FAIL slot_fields k=%0d got %h/%b/%h want %h/%b/%h", k,
                             bus.slot_addr, bus.slot_wstrb, bus.slot_wdata,
                             addr[23:0], wstrb, wdata);
                end
            end
            if (k >= resp_k) begin
                tests_run++;
                if (bus.iomem_rdata !== exp_rdata) begin
                    tests_failed++;
                    $display("[TB] FAIL iomem_rdata addr=%h k=%0d got %h want %h",
                             addr, k, bus.iomem_rdata, exp_rdata);
                end
                tests_run++;
                if (bus_err !== (err && k == resp_k)) begin
                    tests_failed++;
                    $display("[TB] FAIL bus_err addr=%h k=%0d got %b want %b",
                             addr, k, bus_err, (err && k == resp_k));
                end
                tests_run++;
                if (err_count !== 8'(exp_cnt)) begin
                    tests_failed++;
                    $display("[TB] FAIL err_count addr=%h k=%0d got %0d want %0d",
                             addr, k, err_count, exp_cnt);
                end
            end

            if (k >= resp_k) begin
                bus.iomem_valid = 1'b0;
            end else begin
                bus.iomem_addr  = $urandom;
                bus.iomem_wdata = $urandom;
                bus.iomem_wstrb = 4'($urandom);
            end
            for (int s = 0; s < NSLOTS; s++) rd[32*s +: 32] = $urandom;
            rdy = noise ? (4'($urandom) & ~oh) : 4'b0000;
            if (mapped && !err && k == delay + 1) begin
                rdy = rdy | oh;
                if (fix) rd[32*sel +: 32] = fix_val;
                exp_rdata = rd[32*sel +: 32];
            end
            if (late && mapped && err && k == resp_k) rdy = rdy | oh;
            bus.slot_rdata = rd;
            bus.slot_ready = rdy;
        end
        exp_hold = exp_rdata;
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0300_0000;
        bus.iomem_wstrb = 4'hF;
        bus.iomem_wdata = 32'h5555_AAAA;
        bus.slot_ready  = 4'hF;
        bus.slot_rdata  = '1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0 || bus.slot_valid !== 4'h0 ||
            bus.slot_wstrb !== 4'h0 || bus.slot_addr !== 24'h0 || bus.slot_wdata !== 32'h0 ||
            bus_err !== 1'b0 || err_count !== 8'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got rdy=%b rd=%h sv=%b ws=%b sa=%h wd=%h err=%b cnt=%0d want all 0",
                     bus.iomem_ready, bus.iomem_rdata, bus.slot_valid, bus.slot_wstrb,
                     bus.slot_addr, bus.slot_wdata, bus_err, err_count);
        end
        bus.iomem_valid = 1'b0;
        bus.slot_ready  = 4'h0;
        resetn          = 1'b1;
        exp_cnt         = 0;
        exp_hold        = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_read_slot0();
        do_txn(32'h0300_0004, 4'b0000, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'h0000_00A5);
    endtask

    task automatic test_write_slot1();
        do_txn(32'h0400_0010, 4'b0011, 32'h1234_5678, 3, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_unmapped();
        do_txn(32'h0900_0000, 4'b0000, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if (err_count !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL first_error_count got %0d want 1", err_count);
        end
    endtask

    task automatic test_timeout();
        do_txn(32'h0500_0020, 4'b0000, 32'h0, NEVER, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_ready_on_timeout();
        do_txn(32'h0500_0040, 4'b0000, 32'h0, TIMEOUT - 1, 1'b0, 1'b1, 1'b1, 32'hCAFE_0007);
        do_txn(32'h0600_0044, 4'b1111, 32'h0BAD_F00D, 4, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [7:0] top;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: top = 8'h02;
                1: top = 8'h07;
                2: top = 8'(BASE + 8'($urandom_range(0, NSLOTS - 1)));
                3: top = 8'($urandom);
                default: top = 8'(BASE + 8'($urandom_range(0, NSLOTS - 1)));
            endcase
            do_txn({top, 24'($urandom)}, 4'($urandom), $urandom, $urandom_range(0, TIMEOUT + 2),
                   1'($urandom), 1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            do_txn({8'(BASE + 8'(n % NSLOTS)), 24'($urandom)}, 4'($urandom), $urandom, 0,
                   1'b0, 1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0500_0100;
        bus.iomem_wstrb = 4'b0000;
        bus.slot_ready  = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (bus.slot_valid !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL mid_access_select got %b want 0100", bus.slot_valid);
        end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.slot_valid !== 4'h0 || bus.iomem_ready !== 1'b0 || bus.iomem_rdata !== 32'h0 ||
            bus.slot_addr !== 24'h0 || err_count !== 8'h0 || bus_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_access_reset got sv=%b rdy=%b rd=%h sa=%h cnt=%0d err=%b want all 0",
                     bus.slot_valid, bus.iomem_ready, bus.iomem_rdata, bus.slot_addr,
                     err_count, bus_err);
        end
        resetn          = 1'b1;
        bus.iomem_valid = 1'b0;
        exp_cnt         = 0;
        exp_hold        = 32'h0;
        @(negedge clk);
        tests_run++;
        if (bus.iomem_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_resp_after_reset got %b want 0", bus.iomem_ready);
        end
        do_txn(32'h0300_0200, 4'b0000, 32'h0, 2, 1'b0, 1'b0, 1'b1, 32'h1111_2222);
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            do_txn(32'h0900_0000, 4'b0000, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        tests_run++;
        if (err_count !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL err_count_saturate got %h want ff", err_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 0;
        exp_hold     = 32'h0;
        resetn       = 1'b0;
        bus.iomem_valid = 1'b0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_wdata = 32'h0;
        bus.slot_ready  = 4'h0;
        bus.slot_rdata  = '0;
        @(negedge clk);

        test_reset();
        test_read_slot0();
        test_write_slot1();
        test_unmapped();
        test_timeout();
        test_ready_on_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
